// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, LSB-first byte from an external serializer,
// optional parity bit, stop bit. TX line and busy flag are registered.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic [2:0]            state_dbg_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, line_d;
    logic                  busy_q;
    logic                  parity_bit;

    // Request handshake: DATA_VALID is a one-cycle strobe with no ready; it is
    // accepted only on an edge where the FSM is IDLE and silently dropped otherwise.
    assign parity_bit = par_typ_q ^ (^data_q);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        ser_en    = 1'b0;
        line_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    state_d   = START;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            START: begin
                ser_en  = 1'b1;
                line_d  = 1'b0;
                state_d = DATA;
            end
            DATA: begin
                ser_en = 1'b1;
                line_d = ser_data;
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                line_d  = parity_bit;
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= line_d;
            busy_q    <= (state_q != IDLE);
        end
    end

    // In IDLE the serializer sees the live byte so it loads on the acceptance edge.
    assign ser_p_data  = (state_q == IDLE) ? P_DATA : data_q;
    assign TX_OUT      = tx_q;
    assign busy        = busy_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: serializer stub, per-cycle expected line/busy/enable model,
// frame decoder with an expected-byte queue, directed literal frames and random traffic.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic [7:0] ser_p_data;
    logic       TX_OUT;
    logic       busy;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .ser_p_data (ser_p_data),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .state_dbg_o(state_dbg)
    );

    // Serializer stub: loads while disabled, holds bit 0 for the first enabled cycle,
    // then steps one bit per cycle and flags done while presenting bit 7.
    logic [7:0] sr;
    logic [2:0] idx;
    logic       run;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= 8'h00;
            idx <= 3'd0;
            run <= 1'b0;
        end else if (!ser_en) begin
            sr  <= ser_p_data;
            idx <= 3'd0;
            run <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else if (idx != 3'd7) begin
            idx <= idx + 3'd1;
        end
    end

    assign ser_data = sr[idx];
    assign ser_done = run && (idx == 3'd7);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Expected outputs per edge index, filled in when the model accepts a request.
    logic       exp_tx   [0:4095];
    logic       exp_busy [0:4095];
    logic       exp_sen  [0:4095];
    logic       pd_lock  [0:4095];
    logic [7:0] exp_pd   [0:4095];
    logic [7:0] exp_q[$];
    int         next_free = 0;
    int         fr_len;
    logic       par_bit;
    logic       e_tx, e_busy, e_sen;
    logic [7:0] e_pd;
    logic       dec_active = 1'b0;
    logic       dec_armed  = 1'b0;
    int         dec_n = 0;
    logic [7:0] dec_byte;
    logic [7:0] popped;

    initial begin
        for (int k = 0; k < 4096; k++) begin
            exp_tx[k]   = 1'b1;
            exp_busy[k] = 1'b0;
            exp_sen[k]  = 1'b0;
            pd_lock[k]  = 1'b0;
            exp_pd[k]   = 8'h00;
        end
    end

    always begin
        @(posedge clk);
        cyc++;
        if (!rst) begin
            for (int k = 0; k < 16; k++) begin
                exp_tx[cyc+k]   = 1'b1;
                exp_busy[cyc+k] = 1'b0;
                exp_sen[cyc+k]  = 1'b0;
                pd_lock[cyc+k]  = 1'b0;
            end
            next_free = 0;
            exp_q.delete();
        end else if (DATA_VALID && cyc >= next_free) begin
            par_bit = PAR_TYP ^ (^P_DATA);
            fr_len  = PAR_EN ? 12 : 11;
            exp_tx[cyc+1] = 1'b0;
            for (int i = 0; i < 8; i++) exp_tx[cyc+2+i] = P_DATA[i];
            if (PAR_EN) exp_tx[cyc+10] = par_bit;
            for (int k = 1; k < fr_len; k++) exp_busy[cyc+k] = 1'b1;
            for (int k = 0; k <= 8; k++) exp_sen[cyc+k] = 1'b1;
            for (int k = 0; k <= fr_len - 2; k++) begin
                pd_lock[cyc+k] = 1'b1;
                exp_pd[cyc+k]  = P_DATA;
            end
            next_free = cyc + fr_len;
            exp_q.push_back(P_DATA);
        end

        @(negedge clk);
        #1;
        if (!rst) begin
            e_tx = 1'b1; e_busy = 1'b0; e_sen = 1'b0; e_pd = P_DATA;
        end else begin
            e_tx   = exp_tx[cyc];
            e_busy = exp_busy[cyc];
            e_sen  = exp_sen[cyc];
            e_pd   = pd_lock[cyc] ? exp_pd[cyc] : P_DATA;
        end
        check("tx_out", TX_OUT, e_tx);
        check("busy", busy, e_busy);
        check("ser_en", ser_en, e_sen);
        check("ser_p_data", ser_p_data, e_pd);

        if (!rst) begin
            dec_active = 1'b0;
            dec_armed  = 1'b0;
        end else if (dec_active) begin
            dec_byte[dec_n] = TX_OUT;
            dec_n++;
            if (dec_n == 8) begin
                dec_active = 1'b0;
                dec_armed  = 1'b0;
                check("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    popped = exp_q.pop_front();
                    check("frame_byte", dec_byte, popped);
                end
            end
        end else if (!dec_armed) begin
            if (!busy) dec_armed = 1'b1;
        end else if (!TX_OUT) begin
            dec_active = 1'b1;
            dec_n      = 0;
        end
    end

    // Sends one frame and checks TX_OUT at E1..E11 and busy at E1..E12 against literals.
    // An optional second request (pulse_b) is strobed so it is sampled at edge pulse_at.
    task automatic lit_frame(input string nm, input logic [7:0] b, input logic en,
                             input logic typ, input logic [1:11] line, input int fall,
                             input int pulse_at, input logic [7:0] pulse_b);
        @(negedge clk);
        P_DATA = b; PAR_EN = en; PAR_TYP = typ; DATA_VALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        DATA_VALID = 1'b0;
        P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i <= 11) check({nm, "_tx"}, TX_OUT, line[i]);
            check({nm, "_busy"}, busy, (i < fall));
            if (i == pulse_at - 1) begin
                @(negedge clk);
                P_DATA = pulse_b; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
            end else if (i == pulse_at) begin
                @(negedge clk);
                DATA_VALID = 1'b0;
            end
        end
        if (pulse_at == 12) begin
            @(posedge clk);
            #1;
            check({nm, "_next_start"}, TX_OUT, 0);
            check({nm, "_next_busy"}, busy, 1);
        end
    endtask

    initial begin
        rst = 1'b0; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", TX_OUT, 1);
        check("rst_busy", busy, 0);
        check("rst_ser_en", ser_en, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        lit_frame("even_a5",  8'hA5, 1'b1, 1'b0, 11'b01010010101, 12, 0, 8'h00);
        lit_frame("odd_a5",   8'hA5, 1'b1, 1'b1, 11'b01010010111, 12, 0, 8'h00);
        lit_frame("odd_00",   8'h00, 1'b1, 1'b1, 11'b00000000011, 12, 0, 8'h00);
        lit_frame("nopar_3c", 8'h3C, 1'b0, 1'b0, 11'b00011110011, 11, 0, 8'h00);
        lit_frame("ignored",  8'hC3, 1'b1, 1'b0, 11'b01100001101, 12, 4, 8'h00);
        repeat (4) @(negedge clk);
        check("ignored_idle_tx", TX_OUT, 1);
        check("ignored_idle_busy", busy, 0);
        lit_frame("b2b_55",   8'h55, 1'b1, 1'b0, 11'b01010101001, 12, 12, 8'hFF);
        repeat (14) @(negedge clk);

        // Reset in the middle of a 0x96 frame, while bit 3 (a 0) is on the line.
        P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_tx", TX_OUT, 0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_tx", TX_OUT, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_ser_en", ser_en, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_tx", TX_OUT, 1);
        check("post_rst_busy", busy, 0);

        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 299) != 0);
            DATA_VALID = ($urandom_range(0, 5) == 0);
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom_range(0, 1));
            PAR_TYP    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1'b1; DATA_VALID = 1'b0;
        repeat (20) @(negedge clk);
        check("frames_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
